// File: rtl/brent_kung_share_arb.sv
// rtl/brent_kung_share_arb.sv - round-robin shared access to one 16-bit Brent-Kung adder (option macro: BK_ARB_FIXED_PRIO_EN)

module bk_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [16:0] sum
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] pp;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        pp = p;
        // carry-in folded into bit 0, so after the tree g[i] is the carry out of bit i
        g[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                g[4'(i)]  = g[4'(i)] | (pp[4'(i)] & g[4'(i - d)]);
                pp[4'(i)] = pp[4'(i)] & pp[4'(i - d)];
            end
        end
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                g[4'(i)]  = g[4'(i)] | (pp[4'(i)] & g[4'(i - d)]);
                pp[4'(i)] = pp[4'(i)] & pp[4'(i - d)];
            end
        end
        sum = {g[15], p ^ {g[14:0], cin}};
    end
endmodule

module brent_kung_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [16:0]            rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [15:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic               op_cin_q, op_cin_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic [16:0]        rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [16:0]        add_sum;
    logic               grant_en, hs;
    logic [NUM_REQ-1:0] cand;
    logic [ID_W-1:0]    win;

    bk_add16 u_add (.a(op_a_q), .b(op_b_q), .cin(op_cin_q), .sum(add_sum));

`ifdef BK_ARB_FIXED_PRIO_EN
    assign cand = req_valid;
`else
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] above_last, masked;

    // requesters strictly above the last winner go first; otherwise wrap to the lowest
    always_comb begin
        above_last = ~((NUM_REQ'(2) << last_grant_q) - NUM_REQ'(1));
        masked     = req_valid & above_last;
        cand       = (|masked) ? masked : req_valid;
    end

    always_comb last_grant_d = hs ? win : last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= ID_W'(NUM_REQ - 1);
        else        last_grant_q <= last_grant_d;
    end
`endif

    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) win = ID_W'(i);
        end
    end

    assign grant_en  = rst_n && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
    assign hs        = grant_en && (|req_valid);
    assign req_ready = hs ? (NUM_REQ'(1) << win) : '0;
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_cin_d  = op_cin_q;
        op_id_d   = op_id_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        if (hs) begin
            op_a_d   = req_a[{win, 4'b0000} +: 16];
            op_b_d   = req_b[{win, 4'b0000} +: 16];
            op_cin_d = req_cin[win];
            op_id_d  = win;
        end
        case (state_q)
            S_IDLE:  if (hs) state_d = S_CALC;
            S_CALC: begin
                rsp_sum_d = add_sum;
                rsp_id_d  = op_id_q;
                state_d   = S_RESP;
            end
            S_RESP:  if (rsp_ready) state_d = hs ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_cin_q  <= 1'b0;
            op_id_q   <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_cin_q  <= op_cin_d;
            op_id_q   <= op_id_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_brent_kung_share_arb.sv
// tb/tb_brent_kung_share_arb.sv - scoreboard bench for brent_kung_share_arb (follows BK_ARB_FIXED_PRIO_EN)

module tb_brent_kung_share_arb;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_cin;
    logic [16*N-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [16:0]     rsp_sum;
    logic [1:0]      rsp_id;
    logic            busy;

    always #5 clk = ~clk;

    brent_kung_share_arb #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    typedef struct { int id; logic [16:0] sum; } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sbq[$];
    logic [32:0] txq[N][$];
    int          gnt_log[$];
    int          rsp_log[$];
    logic [N-1:0] vld, acc, ccin;
    logic [15:0] ca[N];
    logic [15:0] cb[N];
    int          slot;       // 0 nothing in flight, 1 operation computing, 2 response held
    int          last_ptr;
    int          rdy_mode;   // 0 random, 1 high, 2 low
    bit          gaps, rst_req, rel_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef BK_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_ptr + k) % N;
            if (v[j]) return j;
        end
`endif
        return -1;
    endfunction

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (txq[i].size() != 0) return 0;
        return (vld == '0) && (slot == 0) && (sbq.size() == 0);
    endfunction

    task automatic step();
        int           w;
        logic [N-1:0] exp_rdy;
        bit           allowed, hs_exp, rdy;
        @(negedge clk);
        if (rst_req) begin
            rst_n = 1'b0; rst_req = 1'b0;
            sbq.delete(); slot = 0; last_ptr = N - 1;
        end else if (rel_pending) begin
            rst_n = 1'b1; rel_pending = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(txq[i].pop_front());
                vld[i] = 1'b0; acc[i] = 1'b0;
            end
            if (!vld[i] && txq[i].size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                vld[i] = 1'b1;
                {ca[i], cb[i], ccin[i]} = txq[i][0];
            end
            req_a[16*i +: 16] = ca[i];
            req_b[16*i +: 16] = cb[i];
            req_cin[i]        = ccin[i];
        end
        req_valid = vld;
        rsp_ready = (rdy_mode == 0) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
        #1;
        allowed = rst_n && (slot == 0 || (slot == 2 && rsp_ready));
        w       = pick(vld);
        hs_exp  = allowed && (w >= 0);
        exp_rdy = hs_exp ? (N'(1) << w) : '0;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, slot == 2);
        check("busy", busy, slot != 0);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && vld[i]) begin
                acc[i] = 1'b1;
                gnt_log.push_back(i);
            end
        end
        rdy = rsp_ready;
        @(posedge clk);
        if (hs_exp) begin
            sbq.push_back('{id: w, sum: 17'(ca[w]) + 17'(cb[w]) + 17'(ccin[w])});
            last_ptr = w;
        end
        case (slot)
            0: if (hs_exp) slot = 1;
            1: slot = 2;
            default: if (rdy) slot = hs_exp ? 1 : 0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        check("drain_done", all_idle(), 1);
    endtask

    // monitor: compares every presented response against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    check("rsp_sum", rsp_sum, sbq[0].sum);
                    check("rsp_id", rsp_id, sbq[0].id);
                    if (rsp_ready) begin
                        rsp_log.push_back(int'(rsp_sum));
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        vld = '1; acc = '0; ccin = '0;
        for (int i = 0; i < N; i++) begin ca[i] = '0; cb[i] = '0; end
        req_valid = vld; req_a = '0; req_b = '0; req_cin = '0;
        slot = 0; last_ptr = N - 1; rdy_mode = 1; gaps = 0; rst_req = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        vld = '0; req_valid = '0;
        rel_pending = 1;

        // fairness: everyone holds valid, requester 0 queues a second op
        for (int i = 0; i < N; i++) txq[i].push_back({16'(1000 * i), 16'd7, 1'b0});
        txq[0].push_back({16'd0, 16'd7, 1'b0});
        gnt_log.delete(); rsp_log.delete();
        drain(200);
`ifndef BK_ARB_FIXED_PRIO_EN
        check("rr_count", gnt_log.size(), 5);
        check("rr_g0", gnt_log[0], 0); check("rr_g1", gnt_log[1], 1);
        check("rr_g2", gnt_log[2], 2); check("rr_g3", gnt_log[3], 3);
        check("rr_g4", gnt_log[4], 0);
        check("rr_s0", rsp_log[0], 7);    check("rr_s1", rsp_log[1], 1007);
        check("rr_s2", rsp_log[2], 2007); check("rr_s3", rsp_log[3], 3007);
`endif

        txq[0].push_back({16'd902, 16'd3932, 1'b0});
        gnt_log.delete(); rsp_log.delete();
        drain(50);
        check("single_gnt", gnt_log[0], 0);
        check("single_sum", rsp_log[0], 4834);

        txq[2].push_back({16'hFFFF, 16'hFFFF, 1'b1});
        rsp_log.delete();
        drain(50);
        check("carry_sum", rsp_log[0], 32'h1FFFF);

        // backpressure while holding a response, with other requesters waiting
        txq[1].push_back({16'd19999, 16'd19999, 1'b0});
        rsp_log.delete();
        for (int n = 0; n < 20 && slot != 2; n++) step();
        check("bp_reached_resp", slot, 2);
        txq[0].push_back({16'd5, 16'd6, 1'b1});
        txq[3].push_back({16'd40000, 16'd30000, 1'b0});
        rdy_mode = 2;
        repeat (5) step();
        rdy_mode = 1;
        drain(100);
        check("bp_sum", rsp_log[0], 39998);

        // reset while an operation is computing
        txq[1].push_back({16'd100, 16'd200, 1'b0});
        for (int n = 0; n < 20 && slot != 1; n++) step();
        check("rm_reached_calc", slot, 1);
        txq[0].push_back({16'd1, 16'd2, 1'b0});
        txq[2].push_back({16'd3, 16'd4, 1'b0});
        rst_req = 1; rel_pending = 1;
        gnt_log.delete();
        drain(100);
        check("rm_first_gnt", gnt_log[0], 0);

`ifdef BK_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) txq[1].push_back({16'(k), 16'd9, 1'b0});
        txq[3].push_back({16'd77, 16'd1, 1'b0});
        gnt_log.delete();
        for (int n = 0; n < 100 && txq[1].size() > 0; n++) step();
        check("fp_count", gnt_log.size(), 4);
        foreach (gnt_log[k]) check("fp_gnt", gnt_log[k], 1);
        drain(100);
`endif

        // randomized traffic with request gaps and random backpressure
        gaps = 1; rdy_mode = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                txq[$urandom_range(0, N - 1)].push_back({16'($urandom), 16'($urandom), 1'($urandom)});
            step();
        end
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brent_kung_share_arb.md
# brent_kung_share_arb

Shared-access controller for the 16-bit Brent_Kung prefix adder. It arbitrates between NUM_REQ requesters using valid/ready handshakes and latches the winner's operands into the adder's input registers. It registers the 17-bit sum and returns it with the requester's ID on a single response channel. It sits between the client blocks and one combinational Brent_Kung instance, which it instantiates internally.

## Interface
- NUM_REQ, 4: number of requesters, legal range 2..8.
- ID_W, 2: width of rsp_id; must equal ceil(log2(NUM_REQ)).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  operand A; requester i in bits [16*i+15:16*i].
- req_b  in  16*NUM_REQ  operand B, packed the same way as req_a.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept from the consumer.
- rsp_sum  out  17  {carry_out, sum[15:0]} = a + b + cin.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- Grant is combinational from req_valid. It is evaluated in IDLE, and in RESP when rsp_ready=1. The winner g gets req_ready[g]=1. All other req_ready bits are 0. In every other state, all req_ready bits are 0.
- Arbitration uses round-robin. The search starts at last_grant+1 and wraps modulo NUM_REQ. last_grant updates only on an accepted handshake (req_valid[g] & req_ready[g]).
- On a handshake, op_a, op_b, op_cin and op_id latch the requester's inputs. The FSM then moves to CALC.
- In CALC, the adder inputs are op_a, op_b and op_cin. Its 17-bit result is registered into rsp_sum, and op_id is registered into rsp_id. The FSM then moves to RESP.
- In RESP, rsp_valid=1. rsp_sum and rsp_id stay stable until rsp_ready=1.
  - If rsp_ready=1 and a request is granted in the same cycle, the FSM goes to CALC. This is back-to-back operation.
  - If rsp_ready=1 and no request is pending, the FSM goes to IDLE.
  - If rsp_ready=0, the FSM stays in RESP.
- Arithmetic is unsigned with no truncation. The maximum result is 0xFFFF + 0xFFFF + 1 = 0x1FFFF.
- Requesters must hold req_valid and their operands stable until they see req_ready. Withdrawing a request before it is accepted is illegal; the bench must not do it.
- A request with req_valid low is never granted, even when the pointer targets that requester.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - state=IDLE.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0.
  - req_ready is forced to all 0.
- Latency: handshake at edge E0, result registered at E0+1, rsp_valid high from E0+1 onward.
- Throughput: with rsp_ready held at 1, one result every 2 cycles.
- Reset mid-operation: an in-flight operation and an unconsumed response are discarded. rsp_valid drops immediately.
- After rst_n deasserts, the first grant can happen on the first rising edge.

## Configuration
- Macro BK_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins. last_grant is removed. Starvation of higher-indexed requesters is permitted.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: requester 0 sends a=902, b=3932, cin=0. Expected: req_ready[0] high for 1 cycle, rsp_sum=4834 with rsp_id=0 one cycle after the handshake.
- Carry-out: requester 2 sends a=0xFFFF, b=0xFFFF, cin=1. Expected: rsp_sum=0x1FFFF.
- Round-robin fairness: all 4 requesters hold req_valid, with requester i sending a=1000*i, b=7. Expected: grant order 0,1,2,3,0 and rsp_sum values 7, 1007, 2007, 3007, with no idle cycle between responses.
- Backpressure: hold rsp_ready=0 for 5 cycles while in RESP with a=19999, b=19999. Expected: rsp_sum stays at 39998, rsp_id stays stable, every req_ready bit stays 0, and the FSM enters IDLE or CALC only after rsp_ready rises.
- Reset mid-op: assert rst_n=0 during CALC. Expected: rsp_valid=0 immediately. After release, requester 0 wins first again.
- With BK_ARB_FIXED_PRIO_EN defined: requesters 1 and 3 hold req_valid continuously. Expected: every grant goes to 1 and requester 3 is never served.
